// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch stage. Issues one instruction-memory request at a time,
//   holds the fetched word in the IF/ID register, and uses a one-entry skid
//   buffer to absorb a response that lands while decode is stalled. Redirects
//   flush IF/ID and the skid entry, and any response still in flight from
//   before the redirect is dropped.
//
// Ports
//   clk            : clock, all state changes on the rising edge
//   reset          : synchronous, active-high
//   stall          : decode cannot accept; IF/ID holds
//   redirect_valid : taken branch/jump; flush and refetch from redirect_pc
//   redirect_pc    : redirect target (low two bits are forced to zero)
//   imem_req       : fetch request (high only in the issue state)
//   imem_addr      : word-aligned fetch address
//   imem_gnt       : request accepted when imem_req && imem_gnt
//   imem_rvalid    : read data valid, at least one cycle after the grant
//   imem_rdata     : instruction word returned by memory
//   id_valid       : IF/ID register holds a valid instruction
//   id_pc          : PC of the held instruction
//   id_inst        : held instruction, NOP_INST when nothing is held
//   align_err      : one-cycle pulse after a redirect to a misaligned target
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        id_valid,
    output logic [31:0] id_pc,
    output logic [31:0] id_inst,
    output logic        align_err
);

    // REQ: issuing, WAIT: one request outstanding,
    // FULL: skid entry occupied, DRAIN: a stale response is still due.
    typedef enum logic [1:0] {
        S_REQ   = 2'd0,
        S_WAIT  = 2'd1,
        S_FULL  = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        id_valid_q, id_valid_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] id_inst_q, id_inst_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_inst_q, skid_inst_d;
    logic        align_err_q, align_err_d;

    logic rsp_take;    // a wanted response arrives this cycle
    logic if_id_busy;  // IF/ID holds an instruction decode will not take

    assign rsp_take   = (state_q == S_WAIT) && imem_rvalid;
    assign if_id_busy = id_valid_q && stall;

    // ---------------- state register ----------------
    // NOTE: clocked blocks use non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_REQ;
            fetch_pc_q  <= RESET_PC;
            id_valid_q  <= 1'b0;
            id_pc_q     <= 32'h0000_0000;
            id_inst_q   <= NOP_INST;
            align_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            fetch_pc_q  <= fetch_pc_d;
            id_valid_q  <= id_valid_d;
            id_pc_q     <= id_pc_d;
            id_inst_q   <= id_inst_d;
            align_err_q <= align_err_d;
        end
    end

    // NOTE: the skid payload carries no reset; it is only read in FULL,
    // and FULL is reached only after the payload has been written.
    always_ff @(posedge clk) begin
        skid_pc_q   <= skid_pc_d;
        skid_inst_q <= skid_inst_d;
    end

    // ---------------- next-state logic ----------------
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned (which would infer a latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_REQ: begin
                if (redirect_valid) state_d = imem_gnt ? S_DRAIN : S_REQ;
                else if (imem_gnt)  state_d = S_WAIT;
            end
            S_WAIT: begin
                if (redirect_valid)   state_d = imem_rvalid ? S_REQ : S_DRAIN;
                else if (imem_rvalid) state_d = if_id_busy ? S_FULL : S_REQ;
            end
            S_FULL: begin
                if (redirect_valid || !stall) state_d = S_REQ;
            end
            S_DRAIN: begin
                // A redirect keeps waiting for the stale response, unless that
                // response is arriving right now; staying put then would wait
                // for a response that never comes.
                if (imem_rvalid) state_d = S_REQ;
            end
            default: state_d = S_REQ;
        endcase
    end

    // ---------------- datapath next-state ----------------
    // Priority: redirect, then a fresh response, then the skid entry,
    // then draining IF/ID when decode consumes it.
    always_comb begin
        fetch_pc_d  = fetch_pc_q;
        id_valid_d  = id_valid_q;
        id_pc_d     = id_pc_q;
        id_inst_d   = id_inst_q;
        skid_pc_d   = skid_pc_q;
        skid_inst_d = skid_inst_q;
        align_err_d = 1'b0;

        if (redirect_valid) begin
            fetch_pc_d  = {redirect_pc[31:2], 2'b00};
            id_valid_d  = 1'b0;
            id_inst_d   = NOP_INST;
            align_err_d = (redirect_pc[1:0] != 2'b00);
        end else if (rsp_take) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
            if (if_id_busy) begin
                skid_pc_d   = fetch_pc_q;
                skid_inst_d = imem_rdata;
            end else begin
                id_valid_d = 1'b1;
                id_pc_d    = fetch_pc_q;
                id_inst_d  = imem_rdata;
            end
        end else if ((state_q == S_FULL) && !stall) begin
            id_valid_d = 1'b1;
            id_pc_d    = skid_pc_q;
            id_inst_d  = skid_inst_q;
        end else if (!stall) begin
            id_valid_d = 1'b0;
            id_inst_d  = NOP_INST;
        end
    end

    // ---------------- outputs ----------------
    always_comb begin
        imem_req = (state_q == S_REQ);
    end

    assign imem_addr = fetch_pc_q;
    assign id_valid  = id_valid_q;
    assign id_pc     = id_pc_q;
    assign id_inst   = id_inst_q;
    assign align_err = align_err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch
//   Directed bench for instr_fetch. A small memory responder answers grants
//   after a programmable latency. A transaction-level model (pending / stale
//   response flags, a queue for the skid entry) predicts the outputs and is
//   compared against the DUT at every falling edge; literal expectations at
//   key points pin the model itself.
// -----------------------------------------------------------------------------
module tb_instr_fetch;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [31:0] id_inst;
    logic        align_err;

    instr_fetch #(
        .RESET_PC(32'h0000_0000),
        .NOP_INST(NOP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_gnt      (imem_gnt),
        .imem_rvalid   (imem_rvalid),
        .imem_rdata    (imem_rdata),
        .id_valid      (id_valid),
        .id_pc         (id_pc),
        .id_inst       (id_inst),
        .align_err     (align_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction memory contents: two fixed words, a recognisable pattern elsewhere.
    function automatic logic [31:0] inst_at(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h0050_0093;
            32'h0000_0008: return 32'hFE00_0EE3;
            default:       return {a[19:0], 12'h0B3};
        endcase
    endfunction

    // ---------------- memory responder ----------------
    logic        resp_pend = 1'b0;
    int          resp_cnt  = 0;
    logic [31:0] resp_addr = 32'h0;
    int          lat       = 1;

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        skid_q[$];
    logic [31:0] m_pc       = 32'h0;
    logic        m_pending  = 1'b0;  // wanted response still due
    logic        m_stale    = 1'b0;  // response due that must be dropped
    logic        m_id_valid = 1'b0;
    logic [31:0] m_id_pc    = 32'h0;
    logic [31:0] m_id_inst  = NOP;
    logic        m_align    = 1'b0;

    // The block may ask for a new word only when nothing is in flight and
    // nothing is parked in the skid entry.
    function automatic logic m_req_f();
        return !m_pending && !m_stale && (skid_q.size() == 0);
    endfunction

    // Advance the model across the coming rising edge using the inputs just driven.
    task automatic model_step();
        logic granted;
        ent_t e;
        if (reset) begin
            m_pc = 32'h0; m_pending = 1'b0; m_stale = 1'b0;
            m_id_valid = 1'b0; m_id_pc = 32'h0; m_id_inst = NOP; m_align = 1'b0;
            skid_q.delete();
            return;
        end
        granted = m_req_f() && imem_gnt;
        if (redirect_valid) begin
            m_align    = (redirect_pc[1:0] != 2'b00);
            m_id_valid = 1'b0;
            m_id_inst  = NOP;
            skid_q.delete();
            m_pc       = {redirect_pc[31:2], 2'b00};
            m_stale    = (m_pending && !imem_rvalid) || granted || (m_stale && !imem_rvalid);
            m_pending  = 1'b0;
        end else begin
            m_align = 1'b0;
            if (m_stale && imem_rvalid) m_stale = 1'b0;
            if (m_pending && imem_rvalid) begin
                m_pending = 1'b0;
                if (m_id_valid && stall) begin
                    skid_q.push_back('{pc: m_pc, inst: imem_rdata});
                end else begin
                    m_id_valid = 1'b1; m_id_pc = m_pc; m_id_inst = imem_rdata;
                end
                m_pc = m_pc + 32'd4;
            end else if (skid_q.size() > 0 && !stall) begin
                e = skid_q.pop_front();
                m_id_valid = 1'b1; m_id_pc = e.pc; m_id_inst = e.inst;
            end else if (!stall) begin
                m_id_valid = 1'b0; m_id_inst = NOP;
            end
            if (granted) m_pending = 1'b1;
        end
    endtask

    task automatic compare();
        logic exp_req;
        exp_req = m_req_f();
        check("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) check("imem_addr", imem_addr, m_pc);
        check("id_valid", 32'(id_valid), 32'(m_id_valid));
        check("id_inst", id_inst, m_id_inst);
        if (m_id_valid) check("id_pc", id_pc, m_id_pc);
        check("align_err", 32'(align_err), 32'(m_align));
    endtask

    // One cycle: compare at the falling edge, drive inputs, run responder, step model.
    task automatic cyc(input logic r, input logic s, input logic rv,
                       input logic [31:0] rp, input logic g);
        @(negedge clk);
        compare();
        reset          = r;
        stall          = s;
        redirect_valid = rv;
        redirect_pc    = rp;
        imem_gnt       = g;
        imem_rvalid    = 1'b0;
        if (resp_pend) begin
            resp_cnt--;
            if (resp_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = inst_at(resp_addr);
                resp_pend   = 1'b0;
            end
        end
        if (r) begin
            resp_pend   = 1'b0;
            imem_rvalid = 1'b0;
        end else if (imem_req && g) begin
            check("one_outstanding", 32'(resp_pend), 32'h0);
            resp_pend = 1'b1;
            resp_cnt  = lat;
            resp_addr = imem_addr;
        end
        model_step();
    endtask

    initial begin
        // Reset, then first fetch with immediate grant and 1-cycle data.
        cyc(1, 0, 0, 32'h0, 0);
        cyc(1, 0, 0, 32'h0, 0);
        cyc(0, 0, 0, 32'h0, 1);
        check("rst_req",      32'(imem_req),  32'h1);
        check("rst_addr",     imem_addr,      32'h0);
        check("rst_id_valid", 32'(id_valid),  32'h0);
        check("rst_id_pc",    id_pc,          32'h0);
        check("rst_id_inst",  id_inst,        NOP);
        check("rst_align",    32'(align_err), 32'h0);
        cyc(0, 0, 0, 32'h0, 0);
        cyc(0, 0, 0, 32'h0, 1);
        check("f0_valid", 32'(id_valid), 32'h1);
        check("f0_pc",    id_pc,         32'h0);
        check("f0_inst",  id_inst,       32'h0050_0093);
        check("f0_next",  imem_addr,     32'h4);

        // Response lands while decode is stalled: goes to the skid entry.
        cyc(0, 0, 0, 32'h0, 0);
        cyc(0, 1, 0, 32'h0, 1);
        cyc(0, 1, 0, 32'h0, 0);
        cyc(0, 1, 0, 32'h0, 1);
        check("skid_hold_pc",   id_pc,         32'h4);
        check("skid_hold_inst", id_inst,       32'h0000_40B3);
        check("skid_hold_req",  32'(imem_req), 32'h0);
        cyc(0, 0, 0, 32'h0, 0);
        cyc(0, 0, 0, 32'h0, 0);
        check("skid_out_inst", id_inst,       32'hFE00_0EE3);
        check("skid_out_pc",   id_pc,         32'h8);
        check("skid_out_req",  32'(imem_req), 32'h1);
        check("skid_out_addr", imem_addr,     32'hC);
        lat = 3;
        cyc(0, 0, 0, 32'h0, 1);
        check("drain_valid", 32'(id_valid), 32'h0);
        check("drain_inst",  id_inst,       NOP);

        // Redirect while waiting: stale response dropped, refetch from 0x100.
        cyc(0, 0, 1, 32'h100, 0);
        cyc(0, 0, 0, 32'h0, 1);
        check("redir_valid", 32'(id_valid), 32'h0);
        check("redir_req",   32'(imem_req), 32'h0);
        cyc(0, 0, 0, 32'h0, 1);
        lat = 1;
        cyc(0, 0, 0, 32'h0, 0);
        check("stale_drop", 32'(id_valid), 32'h0);
        check("redir_addr", imem_addr,     32'h100);

        // Misaligned redirect: one-cycle align_err, address aligned down.
        cyc(0, 0, 1, 32'h102, 0);
        cyc(0, 0, 0, 32'h0, 0);
        check("align_pulse", 32'(align_err), 32'h1);
        check("align_addr",  imem_addr,      32'h100);
        cyc(0, 0, 0, 32'h0, 0);
        check("align_clear", 32'(align_err), 32'h0);

        // PC wrap from 0xFFFFFFFC.
        cyc(0, 0, 1, 32'hFFFF_FFFC, 0);
        cyc(0, 0, 0, 32'h0, 1);
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        cyc(0, 0, 0, 32'h0, 0);
        lat = 3;
        cyc(0, 1, 0, 32'h0, 1);
        check("wrap_pc",   id_pc,     32'hFFFF_FFFC);
        check("wrap_next", imem_addr, 32'h0);

        // Reset in WAIT with stall and redirect asserted.
        cyc(1, 1, 1, 32'h200, 0);
        lat = 1;
        cyc(0, 0, 0, 32'h0, 0);
        check("rst2_valid", 32'(id_valid),  32'h0);
        check("rst2_pc",    id_pc,          32'h0);
        check("rst2_inst",  id_inst,        NOP);
        check("rst2_align", 32'(align_err), 32'h0);
        check("rst2_req",   32'(imem_req),  32'h1);
        check("rst2_addr",  imem_addr,      32'h0);

        // Redirect together with a grant, then redirect together with rvalid.
        cyc(0, 0, 1, 32'h40, 1);
        cyc(0, 0, 0, 32'h0, 1);
        check("rg_req", 32'(imem_req), 32'h0);
        cyc(0, 0, 0, 32'h0, 1);
        check("rg_addr", imem_addr, 32'h40);
        cyc(0, 0, 1, 32'h80, 0);
        cyc(0, 0, 0, 32'h0, 0);
        check("rv_req",   32'(imem_req), 32'h1);
        check("rv_addr",  imem_addr,     32'h80);
        check("rv_valid", 32'(id_valid), 32'h0);

        // Mixed traffic checked by the model only.
        for (int i = 0; i < 48; i++) begin
            lat = 1 + (i % 3);
            cyc(0, (i % 7) < 3, (i == 20) || (i == 33),
                (i == 20) ? 32'h306 : 32'h400, (i % 4) != 3);
        end
        cyc(0, 0, 0, 32'h0, 0);
        cyc(0, 0, 0, 32'h0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
